// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, datapath widths and the
// legality check used by the arbiter to mask undefined ALU results.
package alu_pkg;

    localparam int ALU_FUNC_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [ALU_FUNC_W-1:0] {
        ADD  = 5'd1,
        SUB  = 5'd2,
        SLL  = 5'd3,
        SRL  = 5'd4,
        SRA  = 5'd5,
        SEQ  = 5'd6,
        SLT  = 5'd7,
        SLTU = 5'd8,
        XOR  = 5'd9,
        OR   = 5'd10,
        AND  = 5'd11
    } alu_func_e;

    // Codes 1..11 are defined; 0 and 12..31 are reserved.
    function automatic logic is_legal_func(input logic [ALU_FUNC_W-1:0] func);
        return (func >= 5'd1) && (func <= 5'd11);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle of the shared ALU: NUM_REQ packed request
// channels in, one id-tagged response channel out.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 4
);
    import alu_pkg::*;

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ALU_FUNC_W-1:0] req_func;
    logic [NUM_REQ*XLEN-1:0]       req_op_a;
    logic [NUM_REQ*XLEN-1:0]       req_op_b;
    logic [NUM_REQ*TAG_W-1:0]      req_tag;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [TAG_W-1:0]              rsp_tag;
    logic [XLEN-1:0]               rsp_result;
    logic                          rsp_zero;
    logic                          rsp_illegal;

    // Requester side plus response consumer.
    modport master (
        output req_valid, req_func, req_op_a, req_op_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, rsp_illegal
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_func, req_op_a, req_op_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_zero, rsp_illegal
    );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU. Result is only meaningful for legal function
// codes; callers must mask it otherwise.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_FUNC_W-1:0] alu_function,
    input  logic [XLEN-1:0]       operand_a,
    input  logic [XLEN-1:0]       operand_b,
    output logic [XLEN-1:0]       result,
    output logic                  result_equal_zero
);

    // Operation select; shift amounts use the whole operand_b, so any
    // amount of 32 or more shifts everything out.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        result = '0;
        case (alu_function)
            ADD:  result = operand_a + operand_b;
            SUB:  result = operand_a - operand_b;
            SLL:  result = operand_a << operand_b;
            SRL:  result = operand_a >> operand_b;
            SRA:  result = $signed(operand_a) >>> operand_b;
            SEQ:  result = {{(XLEN-1){1'b0}}, operand_a == operand_b};
            SLT:  result = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            SLTU: result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            XOR:  result = operand_a ^ operand_b;
            OR:   result = operand_a | operand_b;
            AND:  result = operand_a & operand_b;
            default: result = '0;
        endcase
    end

    assign result_equal_zero = (result == '0);

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request found searching
// upward from ptr with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // Walk offsets from farthest to nearest so the nearest asserted
    // request (highest priority) is the last one written.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant into an
// issue register, ALU evaluated from it into a result register that drives
// the response channel directly.
// Optional: define ALU_ARB_STALL_CNT_EN to add per-requester saturating
// stall counters on output stall_cnt.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_arbiter_if.slave             bus
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    output logic [NUM_REQ*16-1:0]    stall_cnt
`endif
);

    logic [ID_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  accept;
    logic                  s1_load;
    logic                  s2_load;

    logic                  s1_valid;
    logic [ALU_FUNC_W-1:0] s1_func;
    logic [XLEN-1:0]       s1_op_a;
    logic [XLEN-1:0]       s1_op_b;
    logic [TAG_W-1:0]      s1_tag;
    logic [ID_W-1:0]       s1_id;

    logic                  s2_valid;
    logic [XLEN-1:0]       s2_result;
    logic                  s2_zero;
    logic                  s2_illegal;
    logic [TAG_W-1:0]      s2_tag;
    logic [ID_W-1:0]       s2_id;

    logic [XLEN-1:0]       alu_result;
    logic                  alu_zero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    alu u_alu (
        .alu_function      (s1_func),
        .operand_a         (s1_op_a),
        .operand_b         (s1_op_b),
        .result            (alu_result),
        .result_equal_zero (alu_zero)
    );

    // Each stage advances when it is empty or the stage after it moves.
    assign s2_load       = !s2_valid || bus.rsp_ready;
    assign s1_load       = !s1_valid || s2_load;
    assign bus.req_ready = grant & {NUM_REQ{s1_load}};
    assign accept        = s1_load && (|grant);

    // Priority moves just past the winner on each accept, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Issue register: captures the granted requester's operation.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset as well so the outputs read zero straight out of reset.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_func  <= '0;
            s1_op_a  <= '0;
            s1_op_b  <= '0;
            s1_tag   <= '0;
            s1_id    <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_func <= bus.req_func[grant_idx*ALU_FUNC_W +: ALU_FUNC_W];
                s1_op_a <= bus.req_op_a[grant_idx*XLEN +: XLEN];
                s1_op_b <= bus.req_op_b[grant_idx*XLEN +: XLEN];
                s1_tag  <= bus.req_tag[grant_idx*TAG_W +: TAG_W];
                s1_id   <= grant_idx;
            end
        end
    end

    // Result register: ALU output, forced to zero for reserved codes since
    // the ALU result is meaningless there. Data only changes when a real
    // operation moves in, so a bubble leaves the last response untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
            s2_id      <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag <= s1_tag;
                s2_id  <= s1_id;
                if (is_legal_func(s1_func)) begin
                    s2_result  <= alu_result;
                    s2_zero    <= alu_zero;
                    s2_illegal <= 1'b0;
                end else begin
                    s2_result  <= '0;
                    s2_zero    <= 1'b1;
                    s2_illegal <= 1'b1;
                end
            end
        end
    end

    assign bus.rsp_valid   = s2_valid;
    assign bus.rsp_id      = s2_id;
    assign bus.rsp_tag     = s2_tag;
    assign bus.rsp_result  = s2_result;
    assign bus.rsp_zero    = s2_zero;
    assign bus.rsp_illegal = s2_illegal;

`ifdef ALU_ARB_STALL_CNT_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
        logic [15:0] cnt;

        // Count cycles this requester waits; sticks at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (bus.req_valid[i] && !bus.req_ready[i] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end

        assign stall_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random
// traffic against a transaction-level reference (grant order, 2-deep
// occupancy, response age) kept in queues.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int TAG_W   = 4;
    localparam int ID_W    = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

`ifdef ALU_ARB_STALL_CNT_EN
    logic [NUM_REQ*16-1:0] stall_cnt;
`endif

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef ALU_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int          id;
        logic [3:0]  tag;
        logic [31:0] result;
        logic        zero;
        logic        illegal;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          obs_grant[$];
    int          obs_rsp[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          ptr_m      = 0;
    int          stall_m[NUM_REQ];

    logic        pend_v   [NUM_REQ];
    logic [4:0]  pend_func[NUM_REQ];
    logic [31:0] pend_a   [NUM_REQ];
    logic [31:0] pend_b   [NUM_REQ];
    logic [3:0]  pend_tag [NUM_REQ];
    logic        rdy;

    logic [31:0] last_result;
    logic        last_zero;
    logic        last_illegal;

    // Reference ALU from the function-code definitions.
    function automatic void ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output logic il);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        r  = 32'd0;
        il = 1'b0;
        case (f)
            5'd1:  r = a + b;
            5'd2:  r = a - b;
            5'd3:  r = (b >= 32) ? 32'd0 : (a << b[4:0]);
            5'd4:  r = (b >= 32) ? 32'd0 : (a >> b[4:0]);
            5'd5:  begin
                if (b >= 32) r = a[31] ? ones : 32'd0;
                else         r = (a >> b[4:0]) | (a[31] ? ~(ones >> b[4:0]) : 32'd0);
            end
            5'd6:  r = (a == b) ? 32'd1 : 32'd0;
            5'd7:  r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            5'd8:  r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            5'd9:  r = a ^ b;
            5'd10: r = a | b;
            5'd11: r = a & b;
            default: il = 1'b1;
        endcase
        z = (r == 32'd0);
    endfunction

    function automatic logic any_pend();
        logic p;
        p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) p = p | pend_v[i];
        return p;
    endfunction

    task automatic set_op(input int i, input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
        pend_v[i]    = 1'b1;
        pend_func[i] = f;
        pend_a[i]    = a;
        pend_b[i]    = b;
        pend_tag[i]  = tag;
    endtask

    task automatic rand_op(input int i);
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        f = 5'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) f = 5'd31;
        a = $urandom();
        b = $urandom();
        if ((f >= 5'd3) && (f <= 5'd5) && ($urandom_range(0, 3) != 0)) b = 32'($urandom_range(0, 40));
        if ($urandom_range(0, 7) == 0) b = a;
        set_op(i, f, a, b, 4'($urandom_range(0, 15)));
    endtask

    // One clock: drive at the falling edge, compare mid-cycle, advance the
    // reference on the rising edge's events, return at the next falling edge.
    task automatic run_cycle();
        logic [NUM_REQ-1:0] exp_ready;
        logic               exp_rv;
        int                 g;
        exp_t               e;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]                 = pend_v[i];
            bus.req_func[i*5 +: 5]           = pend_func[i];
            bus.req_op_a[i*32 +: 32]         = pend_a[i];
            bus.req_op_b[i*32 +: 32]         = pend_b[i];
            bus.req_tag[i*TAG_W +: TAG_W]    = pend_tag[i];
        end
        bus.rsp_ready = rdy;
        #1;
        exp_ready = '0;
        g = -1;
        if ((exp_q.size() < 2) || rdy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (ptr_m + k) % NUM_REQ;
                if ((g < 0) && pend_v[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        vectors++;
        if (bus.req_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL req_ready cyc %0d: got %b want %b", cyc, bus.req_ready, exp_ready);
        end
        exp_rv = (exp_q.size() > 0) && (exp_q[0].acc <= cyc - 2);
        vectors++;
        if (bus.rsp_valid !== exp_rv) begin
            miscompares++;
            $display("FAIL rsp_valid cyc %0d: got %b want %b", cyc, bus.rsp_valid, exp_rv);
        end
        if (exp_rv && (bus.rsp_valid === 1'b1)) begin
            vectors++;
            if ({bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal} !==
                {ID_W'(exp_q[0].id), exp_q[0].tag, exp_q[0].result, exp_q[0].zero, exp_q[0].illegal}) begin
                miscompares++;
                $display("FAIL rsp_data cyc %0d: got id=%0d tag=%0d res=%h z=%b il=%b want id=%0d tag=%0d res=%h z=%b il=%b",
                         cyc, bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal,
                         exp_q[0].id, exp_q[0].tag, exp_q[0].result, exp_q[0].zero, exp_q[0].illegal);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend_v[i] && (bus.req_ready[i] === 1'b1)) obs_grant.push_back(i);
            if (pend_v[i] && !exp_ready[i] && (stall_m[i] < 65535)) stall_m[i]++;
        end
        if ((bus.rsp_valid === 1'b1) && rdy) begin
            obs_rsp.push_back(int'(bus.rsp_id));
            last_result  = bus.rsp_result;
            last_zero    = bus.rsp_zero;
            last_illegal = bus.rsp_illegal;
        end
        if (exp_rv && rdy) void'(exp_q.pop_front());
        if (g >= 0) begin
            e.id  = g;
            e.tag = pend_tag[g];
            e.acc = cyc;
            ref_alu(pend_func[g], pend_a[g], pend_b[g], e.result, e.zero, e.illegal);
            exp_q.push_back(e);
            pend_v[g] = 1'b0;
            ptr_m     = (g + 1) % NUM_REQ;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (((exp_q.size() != 0) || any_pend()) && (n < 100)) begin
            run_cycle();
            n++;
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        obs_grant.delete();
        obs_rsp.delete();
        ptr_m = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stall_m[i] = 0;
            pend_v[i]  = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        rst_n = 1'b0;
        clear_model();
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_func  = '0;
        bus.req_op_a  = '0;
        bus.req_op_b  = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_func[i] = '0;
            pend_a[i]    = '0;
            pend_b[i]    = '0;
            pend_tag[i]  = '0;
        end
        do_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b id=%0d tag=%0d res=%h z=%b il=%b want all 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal);
        end
`ifdef ALU_ARB_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        do_reset();
        set_op(0, 5'd1, 32'd5, 32'd7, 4'd3);
        run_cycle();
        vectors++;
        if ((obs_grant.size() != 1) || (obs_grant[0] != 0)) begin
            miscompares++;
            $display("FAIL add_accept: got %0d grants want one grant to requester 0", obs_grant.size());
        end
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_latency1: got rsp_valid %b want 0", bus.rsp_valid);
        end
        run_cycle();
        vectors++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal} !==
            {1'b1, 1'b0, 4'd3, 32'd12, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL add_rsp: got v=%b id=%0d tag=%0d res=%0d z=%b il=%b want v=1 id=0 tag=3 res=12 z=0 il=0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_tag, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal);
        end
        wait_idle();
    endtask

    task automatic test_contention();
        int issued;
        int bad;
        do_reset();
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend_v[i] && (issued < 6)) begin
                    set_op(i, 5'd2, $urandom(), $urandom(), 4'(issued));
                    issued++;
                end
            end
            if ((issued == 6) && !any_pend()) break;
            run_cycle();
        end
        wait_idle();
        bad = 0;
        if ((obs_grant.size() != 6) || (obs_rsp.size() != 6)) bad = 1;
        else for (int k = 0; k < 6; k++) if ((obs_grant[k] != k % 2) || (obs_rsp[k] != k % 2)) bad = 1;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL contention_order: got %0d grants / %0d responses, want 6 of each alternating 0,1",
                     obs_grant.size(), obs_rsp.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] snap_res;
        logic [3:0]  snap_tag;
        do_reset();
        rdy = 1'b0;
        snap_res = '0;
        snap_tag = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NUM_REQ; i++) if (!pend_v[i]) set_op(i, 5'd1, $urandom(), $urandom(), 4'($urandom_range(0, 15)));
            run_cycle();
            if (c == 1) begin
                snap_res = bus.rsp_result;
                snap_tag = bus.rsp_tag;
            end
        end
        vectors++;
        if (obs_grant.size() != 2) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d want 2", obs_grant.size());
        end
        vectors++;
        if (bus.req_ready !== '0) begin
            miscompares++;
            $display("FAIL bp_ready: got %b want 0", bus.req_ready);
        end
        vectors++;
        if ((bus.rsp_valid !== 1'b1) || (bus.rsp_result !== snap_res) || (bus.rsp_tag !== snap_tag)) begin
            miscompares++;
            $display("FAIL bp_hold: got v=%b res=%h tag=%0d want v=1 res=%h tag=%0d",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_tag, snap_res, snap_tag);
        end
        rdy = 1'b1;
        wait_idle();
        vectors++;
        if (obs_rsp.size() != obs_grant.size()) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d responses want %0d", obs_rsp.size(), obs_grant.size());
        end
    endtask

    task automatic test_back_to_back();
        int g0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rand_op(0);
            run_cycle();
        end
        g0 = obs_grant.size();
        wait_idle();
        vectors++;
        if (g0 != 8) begin
            miscompares++;
            $display("FAIL b2b_throughput: got %0d accepts in 8 cycles want 8", g0);
        end
    endtask

    task automatic issue_one(input int i, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        obs_rsp.delete();
        rdy = 1'b1;
        set_op(i, f, a, b, 4'd9);
        for (int n = 0; n < 10; n++) if (obs_rsp.size() == 0) run_cycle();
        vectors++;
        if (obs_rsp.size() == 0) begin
            miscompares++;
            $display("FAIL issue_timeout: got no response for func %0d want one", f);
        end
    endtask

    task automatic test_zero_illegal();
        logic [4:0]  f  [3] = '{5'd2, 5'd0, 5'd12};
        logic [31:0] rr [3] = '{32'd0, 32'd0, 32'd0};
        logic        zz [3] = '{1'b1, 1'b1, 1'b1};
        logic        ii [3] = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            issue_one(k % NUM_REQ, f[k], 32'd9, 32'd9);
            vectors++;
            if ({last_result, last_zero, last_illegal} !== {rr[k], zz[k], ii[k]}) begin
                miscompares++;
                $display("FAIL zero_illegal func %0d: got res=%h z=%b il=%b want res=%h z=%b il=%b",
                         f[k], last_result, last_zero, last_illegal, rr[k], zz[k], ii[k]);
            end
        end
    endtask

    task automatic test_signed();
        logic [4:0]  f  [4] = '{5'd7, 5'd8, 5'd5, 5'd3};
        logic [31:0] aa [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        logic [31:0] bb [4] = '{32'd1, 32'd1, 32'd4, 32'd33};
        logic [31:0] rr [4] = '{32'd1, 32'd0, 32'hF800_0000, 32'd0};
        for (int k = 0; k < 4; k++) begin
            issue_one(k % NUM_REQ, f[k], aa[k], bb[k]);
            vectors++;
            if (last_result !== rr[k]) begin
                miscompares++;
                $display("FAIL signed func %0d: got %h want %h", f[k], last_result, rr[k]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rdy = 1'b0;
        set_op(0, 5'd1, 32'd1, 32'd2, 4'd1);
        set_op(1, 5'd1, 32'd3, 32'd4, 4'd2);
        run_cycle();
        run_cycle();
        set_op(0, 5'd1, 32'd5, 32'd6, 4'd3);
        set_op(1, 5'd1, 32'd7, 32'd8, 4'd4);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_valid: got %b want 0", bus.rsp_valid);
        end
`ifdef ALU_ARB_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== '0) begin
            miscompares++;
            $display("FAIL midreset_stall_cnt: got %h want 0", stall_cnt);
        end
`endif
        clear_model();
        bus.req_valid = '0;
        rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) run_cycle();
        set_op(1, 5'd1, 32'd1, 32'd1, 4'd5);
        set_op(0, 5'd1, 32'd2, 32'd2, 4'd6);
        run_cycle();
        vectors++;
        if ((obs_grant.size() != 1) || (obs_grant[0] != 0)) begin
            miscompares++;
            $display("FAIL midreset_priority: got first grant %0d want 0",
                     (obs_grant.size() > 0) ? obs_grant[0] : -1);
        end
        wait_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) if (!pend_v[i] && ($urandom_range(0, 99) < 60)) rand_op(i);
            run_cycle();
        end
        rdy = 1'b1;
        wait_idle();
`ifdef ALU_ARB_STALL_CNT_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            vectors++;
            if (stall_cnt[i*16 +: 16] !== 16'(stall_m[i])) begin
                miscompares++;
                $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, stall_cnt[i*16 +: 16], stall_m[i]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_zero_illegal();
        test_signed();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
